// File: rtl/pipe_rate_pkg.sv
// Shared types and encodings for the PIPE rate-change controller.
// Generation numbers are 1-based; the PIPE Rate/PCLKRate fields are 0-based.
package pipe_rate_pkg;

    localparam int GEN_MIN = 1;
    localparam int GEN_MAX = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EI_WAIT  = 3'd1,
        ST_SET_RATE = 3'd2,
        ST_WAIT_OK  = 3'd3,
        ST_ACK_WAIT = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    function automatic logic [3:0] gen_to_rate(input logic [2:0] gen);
        return {1'b0, gen - 3'd1};
    endfunction

    function automatic logic [4:0] gen_to_pclkrate(input logic [2:0] gen);
        return {2'b00, gen - 3'd1};
    endfunction

endpackage

// File: rtl/pipe_rate_ctrl_phystatus_collect.sv
// Sticky per-lane PhyStatus collector; all_done_o includes a pulse arriving this cycle.
// Masked-off lanes never record and never block completion.
module phystatus_collect #(
    parameter int LANES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic [LANES-1:0] phystatus_i,
    input  logic [LANES-1:0] mask_i,
    output logic             all_done_o
);

    logic [LANES-1:0] sticky_q;
    logic [LANES-1:0] sticky_d;
    logic [LANES-1:0] seen;

    assign seen       = (sticky_q | phystatus_i) & mask_i;
    assign all_done_o = (seen == mask_i);
    assign sticky_d   = clear_i ? '0 : seen;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

endmodule

// File: rtl/pipe_rate_ctrl.sv
// PIPE rate-change sequencer: EI settle, rate drive, PclkChangeOk/Ack handshake, PhyStatus collect.
// Optional handshake timeout enabled by defining RATE_CHANGE_TIMEOUT_EN.
module pipe_rate_ctrl
    import pipe_rate_pkg::*;
#(
    parameter int LANESNUMBER    = 16,
    parameter int MAX_GEN        = 1,
    parameter int EI_CYCLES      = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2:0]             gen_req,
    input  logic                   change_req,
    input  logic [LANESNUMBER-1:0] lane_mask,
    input  logic [LANESNUMBER-1:0] PhyStatus,
    input  logic                   PclkChangeOk,
    output logic [3:0]             Rate,
    output logic [4:0]             PCLKRate,
    output logic                   PclkChangeAck,
    output logic                   ei_hold,
    output logic                   busy,
    output logic                   done,
    output logic                   reject,
    output logic                   timeout,
    output logic [2:0]             cur_gen
);

    localparam int             EIW     = (EI_CYCLES > 1) ? $clog2(EI_CYCLES) : 1;
    localparam logic [EIW-1:0] EI_LAST = EIW'(EI_CYCLES - 1);
    localparam logic [2:0]     GEN_LO  = 3'(GEN_MIN);
    localparam logic [2:0]     GEN_HI  = 3'((MAX_GEN > GEN_MAX) ? GEN_MAX : MAX_GEN);

    state_e                 state_q, state_d;
    logic [2:0]             tgt_q, tgt_d;
    logic [2:0]             cur_gen_q, cur_gen_d;
    logic [LANESNUMBER-1:0] mask_q, mask_d;
    logic [3:0]             rate_q, rate_d;
    logic [4:0]             pclk_q, pclk_d;
    logic [EIW-1:0]         ei_cnt_q, ei_cnt_d;
    logic                   done_q, done_d;
    logic                   reject_q, reject_d;
    logic                   all_done;
    logic                   gen_ok;

`ifdef RATE_CHANGE_TIMEOUT_EN
    localparam int             TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0]             tmo_cnt_q, tmo_cnt_d;
    logic                      timeout_q, timeout_d;
    logic                      tmo_hit;

    assign tmo_hit = (tmo_cnt_q == TMO_LAST);
`endif

    assign gen_ok = (gen_req >= GEN_LO) && (gen_req <= GEN_HI);

    phystatus_collect #(.LANES(LANESNUMBER)) u_collect (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (state_q != ST_ACK_WAIT),
        .phystatus_i (PhyStatus),
        .mask_i      (mask_q),
        .all_done_o  (all_done)
    );

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        cur_gen_d = cur_gen_q;
        mask_d    = mask_q;
        rate_d    = rate_q;
        pclk_d    = pclk_q;
        ei_cnt_d  = ei_cnt_q;
        done_d    = 1'b0;
        reject_d  = 1'b0;
`ifdef RATE_CHANGE_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (change_req) begin
                    if (!gen_ok) begin
                        reject_d = 1'b1;
                    end else if (gen_req == cur_gen_q) begin
                        done_d = 1'b1;
                    end else begin
                        tgt_d    = gen_req;
                        mask_d   = lane_mask;
                        ei_cnt_d = '0;
                        state_d  = ST_EI_WAIT;
                    end
                end
            end
            ST_EI_WAIT: begin
                if (ei_cnt_q == EI_LAST) begin
                    rate_d  = gen_to_rate(tgt_q);
                    pclk_d  = gen_to_pclkrate(tgt_q);
                    state_d = ST_SET_RATE;
                end else begin
                    ei_cnt_d = ei_cnt_q + 1'b1;
                end
            end
            ST_SET_RATE: begin
                state_d = ST_WAIT_OK;
`ifdef RATE_CHANGE_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            ST_WAIT_OK: begin
                if (PclkChangeOk) begin
                    state_d = ST_ACK_WAIT;
`ifdef RATE_CHANGE_TIMEOUT_EN
                    tmo_cnt_d = '0;
                end else if (tmo_hit) begin
                    rate_d    = gen_to_rate(cur_gen_q);
                    pclk_d    = gen_to_pclkrate(cur_gen_q);
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                end
            end
            ST_ACK_WAIT: begin
                if (all_done) begin
                    cur_gen_d = tgt_q;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
`ifdef RATE_CHANGE_TIMEOUT_EN
                end else if (tmo_hit) begin
                    rate_d    = gen_to_rate(cur_gen_q);
                    pclk_d    = gen_to_pclkrate(cur_gen_q);
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tgt_q     <= 3'd1;
            cur_gen_q <= 3'd1;
            mask_q    <= '0;
            rate_q    <= 4'd0;
            pclk_q    <= 5'd0;
            ei_cnt_q  <= '0;
            done_q    <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            cur_gen_q <= cur_gen_d;
            mask_q    <= mask_d;
            rate_q    <= rate_d;
            pclk_q    <= pclk_d;
            ei_cnt_q  <= ei_cnt_d;
            done_q    <= done_d;
            reject_q  <= reject_d;
        end
    end

`ifdef RATE_CHANGE_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // DONE already releases the link, so only the in-flight states count as busy.
    assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign ei_hold       = busy;
    assign PclkChangeAck = (state_q == ST_ACK_WAIT);
    assign Rate          = rate_q;
    assign PCLKRate      = pclk_q;
    assign done          = done_q;
    assign reject        = reject_q;
    assign cur_gen       = cur_gen_q;

endmodule

// File: tb/tb_pipe_rate_ctrl.sv
// Directed bench for pipe_rate_ctrl (MAX_GEN=3, EI_CYCLES=8, TIMEOUT_CYCLES=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pipe_rate_ctrl;

    logic        clk;
    logic        reset;
    logic [2:0]  gen_req;
    logic        change_req;
    logic [15:0] lane_mask;
    logic [15:0] PhyStatus;
    logic        PclkChangeOk;
    logic [3:0]  Rate;
    logic [4:0]  PCLKRate;
    logic        PclkChangeAck;
    logic        ei_hold;
    logic        busy;
    logic        done;
    logic        reject;
    logic        timeout;
    logic [2:0]  cur_gen;

    int n_cmp = 0;
    int n_err = 0;

    pipe_rate_ctrl #(
        .LANESNUMBER    (16),
        .MAX_GEN        (3),
        .EI_CYCLES      (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .gen_req       (gen_req),
        .change_req    (change_req),
        .lane_mask     (lane_mask),
        .PhyStatus     (PhyStatus),
        .PclkChangeOk  (PclkChangeOk),
        .Rate          (Rate),
        .PCLKRate      (PCLKRate),
        .PclkChangeAck (PclkChangeAck),
        .ei_hold       (ei_hold),
        .busy          (busy),
        .done          (done),
        .reject        (reject),
        .timeout       (timeout),
        .cur_gen       (cur_gen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        logic [19:0] got;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        got = {Rate, PCLKRate, cur_gen, PclkChangeAck, ei_hold, busy, done, reject, timeout};
        n_cmp++;
        if (got !== {4'd0, 5'd0, 3'd1, 6'b0}) begin
            n_err++; $display("FAIL reset_values got=%h exp=%h", got, {4'd0, 5'd0, 3'd1, 6'b0});
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || cur_gen !== 3'd1) begin
            n_err++; $display("FAIL reset_release busy=%b cur_gen=%0d exp busy=0 cur_gen=1", busy, cur_gen);
        end
    endtask

    // Gen1 -> Gen3, Ok at cycle 12, lanes 0-3 staggered, plus an ignored mid-change request.
    task automatic test_change();
        int done_cnt = 0;
        gen_req = 3'd3; lane_mask = 16'h000F; change_req = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            change_req = 1'b0; PhyStatus = '0; PclkChangeOk = 1'b0;
            if (done) done_cnt++;
            n_cmp++;
            if (ei_hold !== (k <= 15) || busy !== (k <= 15)) begin
                n_err++; $display("FAIL chg_ei_busy k=%0d ei_hold=%b busy=%b exp=%b", k, ei_hold, busy, (k <= 15));
            end
            n_cmp++;
            if (PclkChangeAck !== (k >= 12 && k <= 15)) begin
                n_err++; $display("FAIL chg_ack k=%0d got=%b exp=%b", k, PclkChangeAck, (k >= 12 && k <= 15));
            end
            n_cmp++;
            if (done !== (k == 16) || reject !== 1'b0 || timeout !== 1'b0) begin
                n_err++; $display("FAIL chg_pulses k=%0d done=%b reject=%b timeout=%b exp done=%b", k, done, reject, timeout, (k == 16));
            end
            n_cmp++;
            if (Rate !== ((k >= 9) ? 4'd2 : 4'd0) || PCLKRate !== ((k >= 9) ? 5'd2 : 5'd0)) begin
                n_err++; $display("FAIL chg_rate k=%0d Rate=%0d PCLKRate=%0d exp=%0d", k, Rate, PCLKRate, (k >= 9) ? 2 : 0);
            end
            n_cmp++;
            if (cur_gen !== ((k >= 16) ? 3'd3 : 3'd1)) begin
                n_err++; $display("FAIL chg_cur_gen k=%0d got=%0d exp=%0d", k, cur_gen, (k >= 16) ? 3 : 1);
            end
            if (k == 5) begin change_req = 1'b1; gen_req = 3'd2; end
            if (k == 11) PclkChangeOk = 1'b1;
            if (k >= 12 && k <= 15) PhyStatus = 16'(1 << (k - 12));
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_err++; $display("FAIL chg_done_count got=%0d exp=1", done_cnt);
        end
    endtask

    task automatic test_reject();
        logic [2:0] bad [2];
        bad[0] = 3'd4; bad[1] = 3'd0;
        for (int i = 0; i < 2; i++) begin
            gen_req = bad[i]; change_req = 1'b1;
            @(negedge clk);
            change_req = 1'b0;
            n_cmp++;
            if (reject !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                n_err++; $display("FAIL reject_pulse gen=%0d reject=%b busy=%b done=%b exp 1/0/0", bad[i], reject, busy, done);
            end
            @(negedge clk);
            n_cmp++;
            if (reject !== 1'b0 || busy !== 1'b0 || Rate !== 4'd2 || cur_gen !== 3'd3) begin
                n_err++; $display("FAIL reject_after gen=%0d reject=%b busy=%b Rate=%0d cur_gen=%0d exp 0/0/2/3", bad[i], reject, busy, Rate, cur_gen);
            end
        end
    endtask

    task automatic test_same_gen();
        gen_req = 3'd3; change_req = 1'b1;
        @(negedge clk);
        change_req = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || PclkChangeAck !== 1'b0) begin
            n_err++; $display("FAIL same_gen_done done=%b busy=%b ack=%b exp 1/0/0", done, busy, PclkChangeAck);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || PclkChangeAck !== 1'b0) begin
            n_err++; $display("FAIL same_gen_after done=%b busy=%b ack=%b exp 0/0/0", done, busy, PclkChangeAck);
        end
    endtask

    // Gen3 -> Gen1; lanes 4-15 alone must not complete, lanes 0-3 on the exit cycle must.
    task automatic test_mask_ignore();
        int w = 0;
        gen_req = 3'd1; lane_mask = 16'h000F; change_req = 1'b1; PclkChangeOk = 1'b1;
        @(negedge clk);
        change_req = 1'b0;
        while (PclkChangeAck !== 1'b1 && w < 40) begin @(negedge clk); w++; end
        n_cmp++;
        if (PclkChangeAck !== 1'b1) begin
            n_err++; $display("FAIL mask_ack_wait ack=%b exp=1 within 40 cycles", PclkChangeAck);
        end
        PclkChangeOk = 1'b0;
        for (int i = 0; i < 5; i++) begin
            PhyStatus = 16'hFFF0;
            @(negedge clk);
            n_cmp++;
            if (PclkChangeAck !== 1'b1 || done !== 1'b0) begin
                n_err++; $display("FAIL mask_hold i=%0d ack=%b done=%b exp 1/0", i, PclkChangeAck, done);
            end
        end
        PhyStatus = 16'hFFFF;
        @(negedge clk);
        PhyStatus = '0;
        n_cmp++;
        if (done !== 1'b1 || PclkChangeAck !== 1'b0 || busy !== 1'b0 || ei_hold !== 1'b0) begin
            n_err++; $display("FAIL mask_done done=%b ack=%b busy=%b ei=%b exp 1/0/0/0", done, PclkChangeAck, busy, ei_hold);
        end
        n_cmp++;
        if (cur_gen !== 3'd1 || Rate !== 4'd0 || PCLKRate !== 5'd0) begin
            n_err++; $display("FAIL mask_rate cur_gen=%0d Rate=%0d PCLKRate=%0d exp 1/0/0", cur_gen, Rate, PCLKRate);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_mask();
        int w = 0;
        gen_req = 3'd2; lane_mask = 16'h0000; change_req = 1'b1; PclkChangeOk = 1'b1;
        @(negedge clk);
        change_req = 1'b0;
        while (PclkChangeAck !== 1'b1 && w < 40) begin @(negedge clk); w++; end
        n_cmp++;
        if (PclkChangeAck !== 1'b1) begin
            n_err++; $display("FAIL zmask_ack_wait ack=%b exp=1 within 40 cycles", PclkChangeAck);
        end
        PclkChangeOk = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || cur_gen !== 3'd2 || Rate !== 4'd1 || PCLKRate !== 5'd1) begin
            n_err++; $display("FAIL zmask_done done=%b cur_gen=%0d Rate=%0d PCLKRate=%0d exp 1/2/1/1", done, cur_gen, Rate, PCLKRate);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || Rate !== 4'd1) begin
            n_err++; $display("FAIL zmask_hold done=%b busy=%b Rate=%0d exp 0/0/1", done, busy, Rate);
        end
    endtask

    task automatic test_reset_mid();
        int w = 0;
        logic [19:0] got;
        gen_req = 3'd3; lane_mask = 16'h000F; change_req = 1'b1; PclkChangeOk = 1'b1;
        @(negedge clk);
        change_req = 1'b0;
        while (PclkChangeAck !== 1'b1 && w < 40) begin @(negedge clk); w++; end
        n_cmp++;
        if (PclkChangeAck !== 1'b1 || Rate !== 4'd2) begin
            n_err++; $display("FAIL rstmid_ack_wait ack=%b Rate=%0d exp 1/2", PclkChangeAck, Rate);
        end
        PclkChangeOk = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        got = {Rate, PCLKRate, cur_gen, PclkChangeAck, ei_hold, busy, done, reject, timeout};
        n_cmp++;
        if (got !== {4'd0, 5'd0, 3'd1, 6'b0}) begin
            n_err++; $display("FAIL rstmid_values got=%h exp=%h", got, {4'd0, 5'd0, 3'd1, 6'b0});
        end
        @(negedge clk);
        reset = 1'b0;
        PhyStatus = 16'h000F;
        @(negedge clk);
        PhyStatus = '0;
        n_cmp++;
        if (done !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0 || cur_gen !== 3'd1) begin
            n_err++; $display("FAIL rstmid_after done=%b timeout=%b busy=%b cur_gen=%0d exp 0/0/0/1", done, timeout, busy, cur_gen);
        end
    endtask

`ifdef RATE_CHANGE_TIMEOUT_EN
    task automatic test_timeout();
        int w = 0;
        gen_req = 3'd2; lane_mask = 16'h000F; change_req = 1'b1; PclkChangeOk = 1'b0;
        @(negedge clk);
        change_req = 1'b0;
        while (Rate !== 4'd1 && w < 40) begin @(negedge clk); w++; end
        n_cmp++;
        if (Rate !== 4'd1) begin
            n_err++; $display("FAIL tmo_set_rate Rate=%0d exp=1 within 40 cycles", Rate);
        end
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            n_cmp++;
            if (timeout !== (i == 17)) begin
                n_err++; $display("FAIL tmo_pulse i=%0d got=%b exp=%b", i, timeout, (i == 17));
            end
        end
        n_cmp++;
        if (Rate !== 4'd0 || PCLKRate !== 5'd0 || cur_gen !== 3'd1 || ei_hold !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL tmo_restore Rate=%0d PCLKRate=%0d cur_gen=%0d ei=%b busy=%b done=%b exp 0/0/1/0/0/0",
                              Rate, PCLKRate, cur_gen, ei_hold, busy, done);
        end
    endtask
`else
    task automatic test_no_timeout();
        int w = 0;
        gen_req = 3'd2; lane_mask = 16'h000F; change_req = 1'b1; PclkChangeOk = 1'b0;
        @(negedge clk);
        change_req = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (timeout !== 1'b0 || busy !== 1'b1) w++;
        end
        n_cmp++;
        if (w != 0) begin
            n_err++; $display("FAIL no_timeout_wait bad_cycles=%0d exp=0 timeout=%b busy=%b", w, timeout, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        reset = 1'b1; gen_req = 3'd1; change_req = 1'b0;
        lane_mask = '0; PhyStatus = '0; PclkChangeOk = 1'b0;
        test_reset();
        test_change();
        test_reject();
        test_same_gen();
        test_mask_ignore();
        test_zero_mask();
        test_reset_mid();
`ifdef RATE_CHANGE_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
